fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. Owns the program counter, issues word requests to instruction memory over a valid/ready handshake, and buffers returned instructions in order. It presents `Instr`, its PC, `PCPlus4` and the raw immediate field `Instr[31:7]` to the decode stage, where that field drives the immediate extender. Branch and jump redirects flush the buffer and discard any in-flight responses.

---
 rtl/rv32_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: datapath width, reset vector default and
// the fetch buffer entry format.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from storage.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues credit-limited word requests
// and buffers returned instructions in order; redirects flush the buffer.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [24:0] Imm
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             req_fire;
  logic             buf_push, buf_pop, buf_empty;
  logic [CNT_W-1:0] buf_count;
  logic [FETCH_ENTRY_W-1:0] buf_head;
  fetch_entry_t     push_entry, head_entry;

  logic [XLEN-1:0]  trk_head;
  logic [CNT_W-1:0] trk_count;
  logic             trk_empty;
  logic             redirect_lsb_unused;

  assign redirect_lsb_unused = ^RedirectPC[1:0];

  // Credit: outstanding plus buffered fetches never exceed the buffer depth.
  assign imem_req_valid = !reset && !Redirect &&
                          ((SUM_W'(out_cnt_q) + SUM_W'(buf_count)) < SUM_W'(DEPTH));
  assign imem_addr = pc_q;
  assign req_fire  = imem_req_valid && imem_req_ready;

  assign buf_push   = imem_rsp_valid && (drop_cnt_q == '0) && !Redirect;
  assign buf_pop    = InstrValid && InstrReady && !Redirect;
  assign push_entry = '{pc: trk_head, instr: imem_rsp_data};

  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    drop_cnt_d = drop_cnt_q;
    if (Redirect) begin
      pc_d       = {RedirectPC[XLEN-1:2], 2'b00};
      drop_cnt_d = out_cnt_d;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // PC of every accepted request, retired by its response (kept or dropped).
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (imem_rsp_valid),
    .flush_i (1'b0),
    .count_o (trk_count),
    .empty_o (trk_empty),
    .head_o  (trk_head)
  );

  fetch_fifo #(.WIDTH(FETCH_ENTRY_W), .DEPTH(DEPTH)) u_instr_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (buf_push),
    .data_i  (push_entry),
    .pop_i   (buf_pop),
    .flush_i (Redirect),
    .count_o (buf_count),
    .empty_o (buf_empty),
    .head_o  (buf_head)
  );

  assign head_entry = buf_empty ? '0 : fetch_entry_t'(buf_head);
  assign InstrValid = !buf_empty;
  assign Instr      = head_entry.instr;
  assign PCF        = head_entry.pc;
  assign PCPlus4F   = head_entry.pc + XLEN'(4);
  assign Imm        = head_entry.instr[XLEN-1:7];

  // A response with nothing outstanding is a memory protocol violation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rsp_valid && trk_empty));
      assert (trk_count == out_cnt_q);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus randomized memory/decoder/redirect
// traffic checked against a queue-based model of the fetch stream.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] HI_RESET_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        InstrValid, InstrReady = 1'b0;
  logic [31:0] Instr, PCF, PCPlus4F;
  logic [24:0] Imm;

  logic        h_req_valid;
  logic [31:0] h_addr;
  logic        h_rsp_valid = 1'b0;
  logic [31:0] h_rsp_data = '0;
  logic        h_instr_valid;
  logic [31:0] h_instr, h_pcf, h_pcplus4;
  logic [24:0] h_imm;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .PCF(PCF), .PCPlus4F(PCPlus4F), .Imm(Imm)
  );

  fetch_unit #(.RESET_PC(HI_RESET_PC), .DEPTH(DEPTH)) u_dut_hi (
    .clk(clk), .reset(reset),
    .imem_req_valid(h_req_valid), .imem_req_ready(1'b1), .imem_addr(h_addr),
    .imem_rsp_valid(h_rsp_valid), .imem_rsp_data(h_rsp_data),
    .Redirect(1'b0), .RedirectPC(32'h0),
    .InstrValid(h_instr_valid), .InstrReady(1'b1),
    .Instr(h_instr), .PCF(h_pcf), .PCPlus4F(h_pcplus4), .Imm(h_imm)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];
  logic [31:0] bufq[$];
  logic [31:0] next_fetch, cons_pc;
  int          cyc, last_due;
  int          checks, errors;
  int          lat_min, lat_max;
  int unsigned ready_pct, instr_ready_pct;

  logic [31:0] h_addrs[$];
  bit          h_pend;
  logic [31:0] h_pend_addr;
  bit          h_seen_wrap;
  logic [31:0] h_wrap_p4;

  logic        s_instr_valid, s_req_valid;
  logic [31:0] s_pcf;
  logic [24:0] s_imm;

  function automatic logic [31:0] word(input logic [31:0] addr);
    logic [31:0] w;
    if (addr == 32'h0000_0200) w = 32'hFE00_0EE3;
    else w = (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit rst);
    bit          rsp_now, fire, popped, exp_rv, h_fire;
    logic [31:0] exp_pc, exp_instr;
    req_t        e;
    int          due;
    @(negedge clk);
    reset          = rst;
    rsp_now        = !rst && (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? word(pend[0].addr) : $urandom;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    InstrReady     = ($urandom_range(99) < instr_ready_pct);
    Redirect       = redir && !rst;
    RedirectPC     = tgt;
    h_rsp_valid    = !rst && h_pend;
    h_rsp_data     = word(h_pend_addr);
    #1;
    exp_rv = !rst && !redir && ((pend.size() + bufq.size()) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("imem_addr", imem_addr, next_fetch);
    exp_pc    = (bufq.size() > 0) ? bufq[0] : 32'h0;
    exp_instr = (bufq.size() > 0) ? word(bufq[0]) : 32'h0;
    chk("instr_valid", 32'(InstrValid), 32'(bufq.size() > 0));
    chk("instr", Instr, exp_instr);
    chk("pcf", PCF, exp_pc);
    chk("pcplus4", PCPlus4F, exp_pc + 32'd4);
    chk("imm", 32'(Imm), 32'(exp_instr[31:7]));
    s_instr_valid = InstrValid;
    s_req_valid   = imem_req_valid;
    s_pcf         = PCF;
    s_imm         = Imm;

    fire   = !rst && imem_req_valid && imem_req_ready;
    popped = !rst && !redir && (bufq.size() > 0) && InstrReady;
    if (rst) begin
      pend.delete();
      bufq.delete();
      next_fetch = 32'h0;
      cons_pc    = 32'h0;
      last_due   = cyc;
    end else begin
      if (popped) begin
        chk("consume_pc", PCF, cons_pc);
        cons_pc = cons_pc + 32'd4;
        void'(bufq.pop_front());
      end
      if (rsp_now) begin
        e = pend.pop_front();
        if (!e.stale && !redir) bufq.push_back(e.addr);
      end
      if (fire) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{addr: imem_addr, due: due, stale: 1'b0});
        next_fetch = next_fetch + 32'd4;
      end
      if (redir) begin
        bufq.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        next_fetch = {tgt[31:2], 2'b00};
        cons_pc    = {tgt[31:2], 2'b00};
      end
    end

    h_fire = !rst && h_req_valid;
    if (h_fire && h_addrs.size() < 3) h_addrs.push_back(h_addr);
    if (!rst && h_instr_valid && h_pcf == 32'hFFFF_FFFC && !h_seen_wrap) begin
      h_seen_wrap = 1'b1;
      h_wrap_p4   = h_pcplus4;
    end
    h_pend      = h_fire;
    h_pend_addr = h_addr;
    cyc++;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(2))
      0:       t = $urandom;
      1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      default: t = 32'h0000_0100 + 32'($urandom_range(63));
    endcase
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    checks = 0; errors = 0; cyc = 0; last_due = 0;
    lat_min = 1; lat_max = 1; ready_pct = 100; instr_ready_pct = 100;
    next_fetch = 0; cons_pc = 0; h_pend = 0; h_pend_addr = 0;
    h_seen_wrap = 0; h_wrap_p4 = 32'hDEAD_BEEF;

    // Reset and release with 1-cycle memory
    step(0, 0, 1);
    step(0, 0, 1);
    chk("rst_pcplus4", PCPlus4F, 32'h4);
    step(0, 0, 0);
    chk("first_req_valid", 32'(s_req_valid), 32'h1);
    chk("valid_c1", 32'(s_instr_valid), 32'h0);
    step(0, 0, 0);
    chk("valid_c2", 32'(s_instr_valid), 32'h0);
    step(0, 0, 0);
    chk("first_valid", 32'(s_instr_valid), 32'h1);
    chk("first_pcf", s_pcf, 32'h0);
    repeat (8) step(0, 0, 0);

    // Decoder stall: credits run out, then drain without loss
    instr_ready_pct = 0;
    repeat (5) step(0, 0, 0);
    chk("stall_req_valid", 32'(s_req_valid), 32'h0);
    instr_ready_pct = 100;
    repeat (10) step(0, 0, 0);

    // Redirect with two 3-cycle fetches in flight
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend.size() < 2; i++) step(0, 0, 0);
    chk("two_inflight", 32'(pend.size()), 32'd2);
    step(1, 32'h0000_0107, 0);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step(0, 0, 0);
      got = s_instr_valid;
    end
    chk("redir_delivered", 32'(got), 32'h1);
    chk("redir_first_pcf", s_pcf, 32'h0000_0104);

    // Redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (bufq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) begin
        got = 1;
        break;
      end
      step(0, 0, 0);
    end
    chk("rsp_pop_setup", 32'(got), 32'h1);
    step(1, 32'h0000_0040, 0);
    step(0, 0, 0);
    chk("flush_valid", 32'(s_instr_valid), 32'h0);

    // Immediate field of a known branch encoding
    step(1, 32'h0000_0200, 0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 0);
      got = s_instr_valid;
    end
    chk("imm_delivered", 32'(got), 32'h1);
    chk("imm_pcf", s_pcf, 32'h0000_0200);
    chk("imm_value", 32'(s_imm), 32'h01FC_001D);

    // High reset vector wraps through zero
    chk("hi_addr_count", 32'(h_addrs.size()), 32'd3);
    if (h_addrs.size() == 3) begin
      chk("hi_addr0", h_addrs[0], 32'hFFFF_FFF8);
      chk("hi_addr1", h_addrs[1], 32'hFFFF_FFFC);
      chk("hi_addr2", h_addrs[2], 32'h0000_0000);
    end
    chk("hi_wrap_seen", 32'(h_seen_wrap), 32'h1);
    chk("hi_wrap_pcplus4", h_wrap_p4, 32'h0000_0000);

    // Randomized traffic, a mid-run reset, then more traffic
    lat_min = 1; lat_max = 3; ready_pct = 70; instr_ready_pct = 60;
    repeat (300) step($urandom_range(19) == 0, rand_target(), 0);
    step(0, 0, 1);
    repeat (250) step($urandom_range(15) == 0, rand_target(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
